// File: rtl/etc_pkg.sv
`default_nettype none
// ============================================================================
// etc_pkg: tag-class / tag-status encodings and record field layout.
// Rev 1.0
// ============================================================================
package etc_pkg;

   typedef enum logic [1:0] {
      TAG_PASS    = 2'b00,
      TAG_RSVD    = 2'b01,
      TAG_NO_TAG  = 2'b10,
      TAG_INVALID = 2'b11
   } tag_class_e;

   localparam logic [1:0] VEP_VALID = 2'b01;
   localparam logic [1:0] VEP_NONE  = 2'b00;

   // Record = {seq, tag_class, overspeed, speed}; offsets are above the speed field
   localparam int REC_SEQ_W   = 8;
   localparam int REC_TAG_W   = 2;
   localparam int REC_META_W  = 11;
   localparam int REC_OVS_OFS = 0;
   localparam int REC_TAG_OFS = 1;
   localparam int REC_SEQ_OFS = 3;

   function automatic tag_class_e classify_tag(input logic [1:0] vep);
      tag_class_e t;
      if (vep == VEP_VALID)     t = TAG_PASS;
      else if (vep == VEP_NONE) t = TAG_NO_TAG;
      else                      t = TAG_INVALID;
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo: single-clock FIFO; push into a full FIFO succeeds only with a pop.
// Rev 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int C_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [C_AW:0]    r_wr_ptr;
   logic [C_AW:0]    r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB distinguishes full from empty
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                      (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[C_AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + {{C_AW{1'b0}}, 1'b1};
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{C_AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/toll_event_logger.sv
`default_nettype none
// ============================================================================
// toll_event_logger: classifies ETC lane events and buffers records.
// Rev 1.0
// ============================================================================
module toll_event_logger
   import etc_pkg::*;
#(
   parameter int WIDTH_SPEED = 14,
   parameter int SPEED_LIMIT = 60,
   parameter int FIFO_DEPTH  = 8,
   parameter int WIDTH_CNT   = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              done,
   input  logic [WIDTH_SPEED-1:0]            speed,
   input  logic [1:0]                        valid_Epass,
   input  logic                              clr_stat,
   input  logic                              rec_ready,
   output logic                              rec_valid,
   output logic [WIDTH_SPEED+REC_META_W-1:0] rec_data,
   output logic                              overflow,
   output logic [WIDTH_CNT-1:0]              cnt_total,
   output logic [WIDTH_CNT-1:0]              cnt_viol,
   output logic [WIDTH_CNT-1:0]              cnt_drop
);
   localparam int                     C_REC_W = WIDTH_SPEED + REC_META_W;
   localparam logic [WIDTH_SPEED-1:0] C_LIMIT = WIDTH_SPEED'(SPEED_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_PUSH = 2'd2
   } state_e;

   state_e                 r_state;
   state_e                 w_next;
   logic                   r_done_q;
   logic [WIDTH_SPEED-1:0] r_speed;
   logic [1:0]             r_vep;
   logic                   r_ovs;
   tag_class_e             r_tag;
   logic [REC_SEQ_W-1:0]   r_seq;
   logic [C_REC_W-1:0]     w_rec;
   logic                   w_event, w_accept, w_miss, w_in_push;
   logic                   w_full, w_empty, w_pop, w_drop, w_viol;

   function automatic logic [WIDTH_CNT-1:0] sat_add(input logic [WIDTH_CNT-1:0] a,
                                                     input logic [1:0]           inc);
      logic [WIDTH_CNT:0] s;
      s = {1'b0, a} + {{(WIDTH_CNT-1){1'b0}}, inc};
      return s[WIDTH_CNT] ? '1 : s[WIDTH_CNT-1:0];
   endfunction

   assign w_event   = done & ~r_done_q;
   assign w_accept  = w_event & (r_state == ST_IDLE);
   assign w_miss    = w_event & (r_state != ST_IDLE);
   assign w_in_push = (r_state == ST_PUSH);
   assign rec_valid = ~w_empty;
   assign w_pop     = rec_valid & rec_ready;
   assign w_drop    = w_in_push & w_full & ~w_pop;
   assign w_viol    = w_in_push & (r_ovs | (r_tag != TAG_PASS));

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_event) w_next = ST_EVAL;
         ST_EVAL: w_next = ST_PUSH;
         ST_PUSH: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // done_q resets high so a level already present at release is not an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done_q <= 1'b1;
         r_speed  <= '0;
         r_vep    <= '0;
         r_ovs    <= 1'b0;
         r_tag    <= TAG_PASS;
         r_seq    <= '0;
      end else begin
         r_done_q <= done;
         if (w_accept) begin
            r_speed <= speed;
            r_vep   <= valid_Epass;
         end
         if (r_state == ST_EVAL) begin
            r_ovs <= (r_speed > C_LIMIT);
            r_tag <= classify_tag(r_vep);
         end
         if (w_in_push) r_seq <= r_seq + {{(REC_SEQ_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clr_stat) begin
         cnt_total <= '0;
         cnt_viol  <= '0;
         cnt_drop  <= '0;
         overflow  <= 1'b0;
      end else begin
         cnt_total <= sat_add(cnt_total, {1'b0, w_accept});
         cnt_viol  <= sat_add(cnt_viol, {1'b0, w_viol});
         cnt_drop  <= sat_add(cnt_drop, {1'b0, w_miss} + {1'b0, w_drop});
         if (w_drop) overflow <= 1'b1;
      end
   end

   always_comb begin
      w_rec                                             = '0;
      w_rec[WIDTH_SPEED-1:0]                            = r_speed;
      w_rec[WIDTH_SPEED+REC_OVS_OFS]                    = r_ovs;
      w_rec[WIDTH_SPEED+REC_TAG_OFS +: REC_TAG_W]       = r_tag;
      w_rec[WIDTH_SPEED+REC_SEQ_OFS +: REC_SEQ_W]       = r_seq;
   end

   sync_fifo #(
      .WIDTH (C_REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_in_push),
      .i_pop   (rec_ready),
      .i_data  (w_rec),
      .o_data  (rec_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_toll_event_logger.sv
`default_nettype none
// ============================================================================
// tb_toll_event_logger: directed scenarios with a record scoreboard.
// Rev 1.0
// ============================================================================
module tb_toll_event_logger;
   localparam int WS = 14;
   localparam int WC = 16;
   localparam int RW = WS + 11;

   logic          clk = 1'b0;
   logic          reset, done, clr_stat, rec_ready;
   logic [WS-1:0] speed;
   logic [1:0]    valid_Epass;
   logic          rec_valid, overflow;
   logic [RW-1:0] rec_data;
   logic [WC-1:0] cnt_total, cnt_viol, cnt_drop;

   int            total = 0;
   int            bad   = 0;
   logic [RW-1:0] sb[$];
   logic [RW-1:0] mon_exp;
   logic [7:0]    m_seq;

   always #5 clk = ~clk;

   toll_event_logger #(
      .WIDTH_SPEED (WS),
      .SPEED_LIMIT (60),
      .FIFO_DEPTH  (8),
      .WIDTH_CNT   (WC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .done        (done),
      .speed       (speed),
      .valid_Epass (valid_Epass),
      .clr_stat    (clr_stat),
      .rec_ready   (rec_ready),
      .rec_valid   (rec_valid),
      .rec_data    (rec_data),
      .overflow    (overflow),
      .cnt_total   (cnt_total),
      .cnt_viol    (cnt_viol),
      .cnt_drop    (cnt_drop)
   );

   // Records leaving the DUT are checked against the scoreboard in order
   always @(negedge clk) begin
      if (!reset && rec_valid && rec_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL rec_unexpected: got %h, required no record", rec_data);
         end else begin
            mon_exp = sb.pop_front();
            if (rec_data !== mon_exp) begin
               bad++;
               $display("FAIL rec_data: got %h, required %h", rec_data, mon_exp);
            end
         end
      end
   end

   function automatic logic [RW-1:0] model_rec(input logic [7:0] s, input logic [WS-1:0] sp,
                                               input logic [1:0] v);
      logic [1:0] t;
      logic       o;
      t = (v == 2'b01) ? 2'b00 : (v == 2'b00) ? 2'b10 : 2'b11;
      o = (sp > 14'd60);
      return {s, t, o, sp};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fire(input logic [WS-1:0] sp, input logic [1:0] v, input bit stored);
      speed       = sp;
      valid_Epass = v;
      done        = 1'b1;
      if (stored) sb.push_back(model_rec(m_seq, sp, v));
      m_seq++;
      tick(1);
      done = 1'b0;
      tick(2);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      done     = 1'b0;
      clr_stat = 1'b0;
      tick(2);
      sb.delete();
      m_seq = 8'd0;
      reset = 1'b0;
      tick(1);
   endtask

   task automatic clear_stats();
      clr_stat = 1'b1;
      tick(1);
      clr_stat = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", rec_valid); end
      total++; if (rec_data !== '0) begin bad++; $display("FAIL rst_data: got %h, required 0", rec_data); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b, required 0", overflow); end
      total++; if (cnt_total !== 16'd0) begin bad++; $display("FAIL rst_total: got %0d, required 0", cnt_total); end
      total++; if (cnt_viol !== 16'd0) begin bad++; $display("FAIL rst_viol: got %0d, required 0", cnt_viol); end
      total++; if (cnt_drop !== 16'd0) begin bad++; $display("FAIL rst_drop: got %0d, required 0", cnt_drop); end
   endtask

   task automatic test_basic();
      rec_ready   = 1'b1;
      speed       = 14'd45;
      valid_Epass = 2'b01;
      done        = 1'b1;
      sb.push_back(model_rec(m_seq, 14'd45, 2'b01));
      m_seq++;
      tick(1);
      done = 1'b0;
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL lat_n0: got %b, required 0", rec_valid); end
      tick(1);
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL lat_n1: got %b, required 0", rec_valid); end
      tick(1);
      total++; if (rec_valid !== 1'b1) begin bad++; $display("FAIL lat_n2: got %b, required 1", rec_valid); end
      total++; if (rec_data !== {8'd0, 2'b00, 1'b0, 14'd45}) begin
         bad++; $display("FAIL basic_rec: got %h, required %h", rec_data, {8'd0, 2'b00, 1'b0, 14'd45});
      end
      tick(2);
      total++; if (cnt_total !== 16'd1) begin bad++; $display("FAIL basic_total: got %0d, required 1", cnt_total); end
      total++; if (cnt_viol !== 16'd0) begin bad++; $display("FAIL basic_viol: got %0d, required 0", cnt_viol); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL basic_pending: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_overspeed();
      fire(14'd60, 2'b01, 1'b1);
      fire(14'd61, 2'b01, 1'b1);
      tick(2);
      total++; if (cnt_viol !== 16'd1) begin bad++; $display("FAIL ovs_viol: got %0d, required 1", cnt_viol); end
      total++; if (cnt_total !== 16'd3) begin bad++; $display("FAIL ovs_total: got %0d, required 3", cnt_total); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL ovs_pending: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_tag();
      clear_stats();
      fire(14'd45, 2'b00, 1'b1);
      fire(14'd45, 2'b11, 1'b1);
      fire(14'd45, 2'b10, 1'b1);
      tick(2);
      total++; if (cnt_viol !== 16'd3) begin bad++; $display("FAIL tag_viol: got %0d, required 3", cnt_viol); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL tag_pending: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_overflow();
      do_reset();
      rec_ready = 1'b0;
      for (int i = 0; i < 9; i++) fire(WS'(20 + i), 2'b01, (i < 8));
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
      total++; if (cnt_drop !== 16'd1) begin bad++; $display("FAIL ovf_drop: got %0d, required 1", cnt_drop); end
      total++; if (cnt_total !== 16'd9) begin bad++; $display("FAIL ovf_total: got %0d, required 9", cnt_total); end
      total++; if (rec_data !== {8'd0, 2'b00, 1'b0, 14'd20}) begin
         bad++; $display("FAIL ovf_head: got %h, required %h", rec_data, {8'd0, 2'b00, 1'b0, 14'd20});
      end
      // Full FIFO: pop exactly in the PUSH cycle so both must succeed
      speed       = 14'd40;
      valid_Epass = 2'b01;
      done        = 1'b1;
      sb.push_back(model_rec(m_seq, 14'd40, 2'b01));
      m_seq++;
      tick(1);
      done = 1'b0;
      tick(1);
      rec_ready = 1'b1;
      tick(12);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL ovf_pending: got %0d, required 0", sb.size()); end
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b, required 0", rec_valid); end
      total++; if (cnt_drop !== 16'd1) begin bad++; $display("FAIL ovf_pushpop_drop: got %0d, required 1", cnt_drop); end
      fire(14'd45, 2'b01, 1'b1);
      tick(2);
      total++; if (sb.size() != 0) begin bad++; $display("FAIL ovf_next: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_retrigger();
      clear_stats();
      rec_ready   = 1'b1;
      speed       = 14'd30;
      valid_Epass = 2'b01;
      done        = 1'b1;
      sb.push_back(model_rec(m_seq, 14'd30, 2'b01));
      m_seq++;
      tick(1);
      done = 1'b0;
      tick(1);
      done = 1'b1;
      tick(1);
      done = 1'b0;
      tick(3);
      total++; if (cnt_drop !== 16'd1) begin bad++; $display("FAIL retrig_drop: got %0d, required 1", cnt_drop); end
      total++; if (cnt_total !== 16'd1) begin bad++; $display("FAIL retrig_total: got %0d, required 1", cnt_total); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL retrig_pending: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_misc();
      // Reset mid-operation with done held high across release
      rec_ready = 1'b0;
      fire(14'd50, 2'b01, 1'b0);
      fire(14'd50, 2'b01, 1'b0);
      done = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      sb.delete();
      m_seq = 8'd0;
      tick(4);
      total++; if (cnt_total !== 16'd0) begin bad++; $display("FAIL hold_total: got %0d, required 0", cnt_total); end
      total++; if (rec_valid !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b, required 0", rec_valid); end
      total++; if (cnt_drop !== 16'd0) begin bad++; $display("FAIL hold_drop: got %0d, required 0", cnt_drop); end
      done      = 1'b0;
      rec_ready = 1'b1;
      tick(1);
      for (int i = 0; i < 257; i++) fire(WS'(i % 50), 2'b01, 1'b1);
      tick(2);
      total++; if (cnt_total !== 16'd257) begin bad++; $display("FAIL wrap_total: got %0d, required 257", cnt_total); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL wrap_pending: got %0d, required 0", sb.size()); end
      // Clear coinciding with an accepted event
      speed       = 14'd10;
      valid_Epass = 2'b01;
      done        = 1'b1;
      clr_stat    = 1'b1;
      sb.push_back(model_rec(m_seq, 14'd10, 2'b01));
      m_seq++;
      tick(1);
      clr_stat = 1'b0;
      done     = 1'b0;
      total++; if (cnt_total !== 16'd0) begin bad++; $display("FAIL clr_total: got %0d, required 0", cnt_total); end
      tick(4);
      total++; if (cnt_total !== 16'd0) begin bad++; $display("FAIL clr_total_after: got %0d, required 0", cnt_total); end
      total++; if (cnt_viol !== 16'd0) begin bad++; $display("FAIL clr_viol: got %0d, required 0", cnt_viol); end
      total++; if (sb.size() != 0) begin bad++; $display("FAIL clr_pending: got %0d, required 0", sb.size()); end
   endtask

   initial begin
      reset       = 1'b1;
      done        = 1'b0;
      clr_stat    = 1'b0;
      rec_ready   = 1'b0;
      speed       = '0;
      valid_Epass = 2'b00;
      m_seq       = 8'd0;
      test_reset();
      test_basic();
      test_overspeed();
      test_tag();
      test_overflow();
      test_retrigger();
      test_misc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
